// File: rtl/tiny6502_bus_sequencer.sv
// tiny6502_bus_sequencer
//   Time-multiplexes a 6502-style CPU bus cycle onto an 8-bit pin group.
//   Each CPU cycle walks the phases ALO -> AHI -> CTRL -> DATA -> STEP.
//   DATA waits for ext_rdy. If ext_rdy stays low for WAIT_MAX wait states,
//   the cycle is forced to complete.
//
// Ports
//   clk, rst, ena      clock, synchronous active-high reset, advance enable
//   cpu_addr/rw/sync   CPU address and cycle flags (sampled leaving ALO)
//   cpu_dout           CPU write data (sampled leaving ALO)
//   ext_rdy            external memory ready, completes DATA
//   bus_din            external data pins, input path
//   pin_out/pin_phase  multiplexed address/control byte and current phase
//   bus_dout/bus_oe    external data pins, output value and enable
//   cpu_clk_en         one-cycle CPU advance pulse (STEP with ena)
//   cpu_din            registered read data returned to the CPU
//   bus_timeout        sticky forced-completion flag, cleared only by reset
module tiny6502_bus_sequencer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic        cpu_sync,
    input  logic [7:0]  cpu_dout,
    input  logic        ext_rdy,
    input  logic [7:0]  bus_din,
    output logic [7:0]  pin_out,
    output logic [1:0]  pin_phase,
    output logic [7:0]  bus_dout,
    output logic [7:0]  bus_oe,
    output logic        cpu_clk_en,
    output logic [7:0]  cpu_din,
    output logic        bus_timeout
);

    localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

    typedef enum logic [2:0] {
        ALO  = 3'd0,
        AHI  = 3'd1,
        CTRL = 3'd2,
        DATA = 3'd3,
        STEP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    // Only the high address byte is needed after ALO; the low byte is
    // presented live while in ALO, so it is never replayed from the snapshot.
    logic [7:0]  snap_ahi_q, snap_ahi_d;
    logic        snap_rw_q, snap_rw_d;
    logic        snap_sync_q, snap_sync_d;
    logic [7:0]  snap_dout_q, snap_dout_d;
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        snap_ahi_d  = snap_ahi_q;
        snap_rw_d   = snap_rw_q;
        snap_sync_d = snap_sync_q;
        snap_dout_d = snap_dout_q;
        cpu_din_d   = cpu_din_q;
        timeout_d   = timeout_q;
        if (ena) begin
            unique case (state_q)
                ALO: begin
                    state_d     = AHI;
                    snap_ahi_d  = cpu_addr[15:8];
                    snap_rw_d   = cpu_rw;
                    snap_sync_d = cpu_sync;
                    snap_dout_d = cpu_dout;
                end
                AHI: state_d = CTRL;
                CTRL: begin
                    state_d    = DATA;
                    wait_cnt_d = '0;
                end
                DATA: begin
                    // ext_rdy is tested first so a ready arriving on the
                    // last allowed wait state still counts as a normal exit.
                    if (ext_rdy) begin
                        state_d = STEP;
                        if (snap_rw_q) cpu_din_d = bus_din;
                    end else if (wait_cnt_q == WAIT_MAX_C) begin
                        state_d   = STEP;
                        timeout_d = 1'b1;
                        if (snap_rw_q) cpu_din_d = '1;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                STEP: state_d = ALO;
                default: state_d = ALO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ALO;
            wait_cnt_q  <= '0;
            snap_ahi_q  <= '0;
            snap_rw_q   <= 1'b0;
            snap_sync_q <= 1'b0;
            snap_dout_q <= '0;
            cpu_din_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            snap_ahi_q  <= snap_ahi_d;
            snap_rw_q   <= snap_rw_d;
            snap_sync_q <= snap_sync_d;
            snap_dout_q <= snap_dout_d;
            cpu_din_q   <= cpu_din_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        pin_out    = '0;
        pin_phase  = 2'd3;
        bus_dout   = '0;
        bus_oe     = '0;
        cpu_clk_en = 1'b0;
        unique case (state_q)
            ALO: begin
                pin_out   = cpu_addr[7:0];
                pin_phase = 2'd0;
            end
            AHI: begin
                pin_out   = snap_ahi_q;
                pin_phase = 2'd1;
            end
            CTRL: begin
                pin_out   = {5'b0, timeout_q, snap_sync_q, snap_rw_q};
                pin_phase = 2'd2;
            end
            DATA: begin
                if (!snap_rw_q) begin
                    bus_oe   = '1;
                    bus_dout = snap_dout_q;
                end
            end
            STEP: cpu_clk_en = ena;
            default: ;
        endcase
    end

    assign cpu_din     = cpu_din_q;
    assign bus_timeout = timeout_q;

endmodule

// File: tb/tb_tiny6502_bus_sequencer.sv
// Testbench for tiny6502_bus_sequencer: each scenario pushes the expected
// per-cycle pin/bus/CPU view to a scoreboard queue and pops one entry per
// clock as the DUT advances.
module tb_tiny6502_bus_sequencer;

    localparam int WAIT_MAX = 15;
    localparam int AT_STEP  = 99;   // freeze position marker: the STEP cycle

    logic        clk = 1'b0;
    logic        rst, ena;
    logic [15:0] cpu_addr;
    logic        cpu_rw, cpu_sync;
    logic [7:0]  cpu_dout;
    logic        ext_rdy;
    logic [7:0]  bus_din;
    logic [7:0]  pin_out;
    logic [1:0]  pin_phase;
    logic [7:0]  bus_dout, bus_oe;
    logic        cpu_clk_en;
    logic [7:0]  cpu_din;
    logic        bus_timeout;

    tiny6502_bus_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_sync   (cpu_sync),
        .cpu_dout   (cpu_dout),
        .ext_rdy    (ext_rdy),
        .bus_din    (bus_din),
        .pin_out    (pin_out),
        .pin_phase  (pin_phase),
        .bus_dout   (bus_dout),
        .bus_oe     (bus_oe),
        .cpu_clk_en (cpu_clk_en),
        .cpu_din    (cpu_din),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ph;
        logic [7:0] pin;
        logic [7:0] oe;
        logic [7:0] dout;
        logic       ce;
        logic [7:0] din;
        logic       to;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [7:0]  din_m;     // model of cpu_din
    logic        to_m;      // model of bus_timeout

    function automatic obs_t sample();
        obs_t o;
        o.ph   = pin_phase;
        o.pin  = pin_out;
        o.oe   = bus_oe;
        o.dout = bus_dout;
        o.ce   = cpu_clk_en;
        o.din  = cpu_din;
        o.to   = bus_timeout;
        return o;
    endfunction

    // Runs one full CPU cycle starting in ALO (called #1 after a clock edge).
    // nwait: DATA cycles with ext_rdy low before it rises (>WAIT_MAX = stuck).
    // frz_at/frz_len: hold ena low for frz_len clocks at that phase position.
    task automatic txn(input string name, input logic [15:0] a, input logic rw,
                       input logic sync, input logic [7:0] d, input logic [7:0] bd,
                       input int nwait, input int frz_at, input int frz_len);
        int   ndata  = (nwait > WAIT_MAX) ? WAIT_MAX + 1 : nwait + 1;
        bit   forced = (nwait > WAIT_MAX);
        int   total  = 4 + ndata;
        int   fpos   = (frz_at == AT_STEP) ? total - 1 : frz_at;
        int   pos    = 0;
        int   fz     = 0;
        int   cyc    = 0;
        obs_t e, o;

        for (int i = 0; i < total; i++) begin
            e = '{ph: 2'd3, pin: 8'h00, oe: 8'h00, dout: 8'h00, ce: 1'b0,
                  din: din_m, to: to_m};
            if (i == 0) begin
                e.ph = 2'd0; e.pin = a[7:0];
            end else if (i == 1) begin
                e.ph = 2'd1; e.pin = a[15:8];
            end else if (i == 2) begin
                e.ph = 2'd2; e.pin = {5'b0, to_m, sync, rw};
            end else if (i < 3 + ndata) begin
                if (!rw) begin e.oe = 8'hFF; e.dout = d; end
            end else begin
                if (forced) to_m = 1'b1;
                if (rw) din_m = forced ? 8'hFF : bd;
                e.din = din_m; e.to = to_m; e.ce = 1'b1;
            end
            if (i == fpos) begin
                for (int k = 0; k < frz_len; k++) begin
                    obs_t f = e;
                    f.ce = 1'b0;
                    exp_q.push_back(f);
                end
            end
            exp_q.push_back(e);
        end

        while (pos < total) begin
            ena      = !(pos == fpos && fz < frz_len);
            cpu_addr = a; cpu_rw = rw; cpu_sync = sync; cpu_dout = d;
            bus_din  = bd;
            ext_rdy  = (pos >= 3 && pos < 3 + ndata) ? ((pos - 3) >= nwait) : 1'b0;
            #1;
            o = sample();
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL %s cyc%0d: scoreboard empty", name, cyc);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL %s cyc%0d: got ph=%0d pin=%h oe=%h dout=%h ce=%b din=%h to=%b, expected ph=%0d pin=%h oe=%h dout=%h ce=%b din=%h to=%b",
                             name, cyc, o.ph, o.pin, o.oe, o.dout, o.ce, o.din, o.to,
                             e.ph, e.pin, e.oe, e.dout, e.ce, e.din, e.to);
                end
            end
            @(posedge clk); #1;
            if (ena) pos++; else fz++;
            cyc++;
        end
        ena = 1'b1;
    endtask

    task automatic check_rst_state(input string name, input logic [15:0] a);
        obs_t e, o;
        exp_q.push_back('{ph: 2'd0, pin: a[7:0], oe: 8'h00, dout: 8'h00,
                          ce: 1'b0, din: 8'h00, to: 1'b0});
        din_m = 8'h00; to_m = 1'b0;
        cpu_addr = a;
        #1;
        o = sample();
        e = exp_q.pop_front();
        tests++;
        if (o !== e) begin
            fails++;
            $display("FAIL %s: got ph=%0d pin=%h oe=%h dout=%h ce=%b din=%h to=%b, expected ph=%0d pin=%h oe=00 dout=00 ce=0 din=00 to=0",
                     name, o.ph, o.pin, o.oe, o.dout, o.ce, o.din, o.to, e.ph, e.pin);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; ext_rdy = 1'b1; bus_din = 8'h33;
        cpu_addr = 16'h1234; cpu_rw = 1'b0; cpu_sync = 1'b0; cpu_dout = 8'h99;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_rst_state("reset", 16'h4321);
    endtask

    task automatic test_read();
        txn("read", 16'hABCD, 1'b1, 1'b1, 8'h00, 8'h5A, 0, -1, 0);
    endtask

    task automatic test_write();
        txn("write", 16'h0200, 1'b0, 1'b0, 8'h77, 8'hC3, 0, -1, 0);
    endtask

    task automatic test_wait_states();
        txn("wait3", 16'h1F2E, 1'b1, 1'b0, 8'h00, 8'h3C, 3, -1, 0);
        txn("wait2_wr", 16'h8001, 1'b0, 1'b1, 8'hA5, 8'h11, 2, -1, 0);
    endtask

    task automatic test_freeze();
        txn("freeze_ahi", 16'hBEEF, 1'b1, 1'b0, 8'h00, 8'h42, 0, 1, 4);
        txn("freeze_step", 16'h6502, 1'b1, 1'b1, 8'h00, 8'h24, 1, AT_STEP, 2);
    endtask

    task automatic test_coincidence();
        txn("coincide", 16'h0F0F, 1'b1, 1'b0, 8'h00, 8'h81, WAIT_MAX, -1, 0);
    endtask

    task automatic test_timeout();
        txn("timeout_rd", 16'hFFFC, 1'b1, 1'b0, 8'h00, 8'h5A, 40, -1, 0);
        txn("after_to_rd", 16'h1234, 1'b1, 1'b1, 8'h00, 8'h66, 0, -1, 0);
        txn("timeout_wr", 16'h0300, 1'b0, 1'b0, 8'h12, 8'h77, 40, -1, 0);
    endtask

    task automatic test_reset_mid_data();
        int ce_seen = 0;
        ena = 1'b1; cpu_addr = 16'hC0DE; cpu_rw = 1'b1; cpu_sync = 1'b0;
        cpu_dout = 8'h00; bus_din = 8'hEE; ext_rdy = 1'b0;
        // ALO, AHI, CTRL and two DATA wait cycles, then reset in the third.
        for (int i = 0; i < 6; i++) begin
            #1;
            if (cpu_clk_en) ce_seen++;
            if (i == 5) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        tests++;
        if (ce_seen != 0) begin
            fails++;
            $display("FAIL rst_mid_data_ce: got %0d cpu_clk_en pulses, expected 0", ce_seen);
        end
        check_rst_state("rst_mid_data", 16'hC0DE);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            logic [15:0] a  = 16'($urandom);
            logic        rw = 1'($urandom);
            logic [7:0]  d  = 8'($urandom);
            logic [7:0]  bd = 8'($urandom);
            txn("b2b", a, rw, 1'($urandom), d, bd, int'($urandom_range(0, 4)), -1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_wait_states();
        test_freeze();
        test_coincidence();
        test_timeout();
        test_reset_mid_data();
        test_read();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
